// File: rtl/thread_stack_unit.sv
// Multi-thread hardware stack unit.
// Each thread owns a private LIFO of DEPTH words plus a count and a sticky
// error bit. One operation is accepted per cycle; its result is registered
// and presented on the next cycle. The stack state is updated at the same
// edge that registers the result, so back-to-back operations on the same
// thread see fully up-to-date state without any forwarding network.
module thread_stack_unit #(
    parameter int THREADS = 2,
    parameter int DEPTH   = 256,
    parameter int WIDTH   = 16,
    localparam int TW     = $clog2(THREADS),
    localparam int NW     = $clog2(DEPTH),
    localparam int CW     = NW + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [TW-1:0]      op_thread,
    input  logic [3:0]         op_code,
    input  logic [WIDTH-1:0]   op_imm,
    input  logic [NW-1:0]      op_n,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [TW-1:0]      res_thread,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_err,
    output logic               res_torf,
    output logic [THREADS-1:0] err
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_POP  = 4'h2;
    localparam logic [3:0] OP_DUP  = 4'h3;
    localparam logic [3:0] OP_GET  = 4'h4;
    localparam logic [3:0] OP_PUT  = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_AND  = 4'h8;
    localparam logic [3:0] OP_OR   = 4'h9;
    localparam logic [3:0] OP_XOR  = 4'hA;
    localparam logic [3:0] OP_LT   = 4'hB;
    localparam logic [3:0] OP_TEST = 4'hC;
    localparam logic [3:0] OP_CLR  = 4'hD;

    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    // Storage is deliberately not reset; cnt gates every observable read.
    logic [WIDTH-1:0] mem_q [THREADS][DEPTH];

    logic [CW-1:0]      cnt_q [THREADS];
    logic [CW-1:0]      cnt_d [THREADS];
    logic [THREADS-1:0] err_q, err_d;
    logic               res_valid_q, res_valid_d;
    logic [TW-1:0]      res_thread_q, res_thread_d;
    logic [WIDTH-1:0]   res_data_q, res_data_d;
    logic               res_err_q, res_err_d;
    logic               res_torf_q, res_torf_d;

    logic               accept;
    logic [CW-1:0]      cnt_cur, n_cnt, need_n, need_n1;
    logic [CW-1:0]      top_i, sec_i, nth_i;
    logic [WIDTH-1:0]   top_v, sec_v, nth_v, cur_top, alu_v;
    logic               empty, full, fault, clr;
    logic               wr_en;
    logic [NW-1:0]      wr_addr;
    logic [WIDTH-1:0]   wr_data;
    logic [WIDTH-1:0]   r_data;
    logic               r_torf;

    assign op_ready   = !reset && !(res_valid_q && !res_ready);
    assign accept     = op_valid && op_ready;
    assign res_valid  = res_valid_q;
    assign res_thread = res_thread_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign res_torf   = res_torf_q;
    assign err        = err_q;

    // Operand fetch: top, second, and the entry op_n below the top of the selected thread.
    always_comb begin
        cnt_cur = cnt_q[op_thread];
        need_n  = {1'b0, op_n};
        need_n1 = need_n + CW'(1);
        top_i   = cnt_cur - CW'(1);
        sec_i   = cnt_cur - CW'(2);
        nth_i   = cnt_cur - CW'(1) - need_n;
        top_v   = mem_q[op_thread][top_i[NW-1:0]];
        sec_v   = mem_q[op_thread][sec_i[NW-1:0]];
        nth_v   = mem_q[op_thread][nth_i[NW-1:0]];
        empty   = (cnt_cur == '0);
        full    = (cnt_cur == CNT_FULL);
        cur_top = empty ? '0 : top_v;
    end

    // Binary ALU: a is the entry below top, b is the top.
    always_comb begin
        alu_v = '0;
        case (op_code)
            OP_ADD:  alu_v = sec_v + top_v;
            OP_SUB:  alu_v = sec_v - top_v;
            OP_AND:  alu_v = sec_v & top_v;
            OP_OR:   alu_v = sec_v | top_v;
            OP_XOR:  alu_v = sec_v ^ top_v;
            OP_LT:   alu_v = (sec_v < top_v) ? WIDTH'(1) : '0;
            default: alu_v = '0;
        endcase
    end

    // Operation decode: new count, memory write, result word, fault detection.
    always_comb begin
        n_cnt   = cnt_cur;
        wr_en   = 1'b0;
        wr_addr = cnt_cur[NW-1:0];
        wr_data = op_imm;
        fault   = 1'b0;
        clr     = 1'b0;
        r_data  = cur_top;
        r_torf  = 1'b0;
        case (op_code)
            OP_NOP: ;
            OP_PUSH: begin
                fault   = full;
                wr_en   = 1'b1;
                n_cnt   = cnt_cur + CW'(1);
                r_data  = op_imm;
            end
            OP_POP: begin
                fault   = (cnt_cur < need_n);
                n_cnt   = cnt_cur - need_n;
                r_data  = (cnt_cur == need_n) ? '0 : nth_v;
            end
            OP_DUP: begin
                fault   = empty || full;
                wr_en   = 1'b1;
                wr_data = top_v;
                n_cnt   = cnt_cur + CW'(1);
                r_data  = top_v;
            end
            OP_GET: begin
                fault   = full || (cnt_cur < need_n1);
                wr_en   = 1'b1;
                wr_data = nth_v;
                n_cnt   = cnt_cur + CW'(1);
                r_data  = nth_v;
            end
            OP_PUT: begin
                fault   = (cnt_cur < need_n1);
                wr_en   = 1'b1;
                wr_addr = nth_i[NW-1:0];
                wr_data = top_v;
                r_data  = top_v;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LT: begin
                fault   = (cnt_cur < CW'(2));
                wr_en   = 1'b1;
                wr_addr = sec_i[NW-1:0];
                wr_data = alu_v;
                n_cnt   = cnt_cur - CW'(1);
                r_data  = alu_v;
            end
            OP_TEST: begin
                fault   = empty;
                n_cnt   = cnt_cur - CW'(1);
                r_torf  = (top_v != '0);
                r_data  = (cnt_cur == CW'(1)) ? '0 : sec_v;
            end
            OP_CLR: begin
                clr     = 1'b1;
                n_cnt   = '0;
                r_data  = '0;
            end
            default: fault = 1'b1;
        endcase
        // A faulting operation leaves the stack untouched and reports the current top.
        if (fault) begin
            n_cnt  = cnt_cur;
            wr_en  = 1'b0;
            r_data = cur_top;
            r_torf = 1'b0;
        end
        wr_en = wr_en && accept;
    end

    // Next-state for counts, sticky errors and the result register.
    always_comb begin
        cnt_d        = cnt_q;
        err_d        = err_q;
        res_valid_d  = res_valid_q && !res_ready;
        res_thread_d = res_thread_q;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        res_torf_d   = res_torf_q;
        if (accept) begin
            cnt_d[op_thread] = n_cnt;
            if (fault) err_d[op_thread] = 1'b1;
            if (clr)   err_d[op_thread] = 1'b0;
            res_valid_d  = 1'b1;
            res_thread_d = op_thread;
            res_data_d   = r_data;
            res_err_d    = fault;
            res_torf_d   = r_torf;
        end
    end

    // Control and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int t = 0; t < THREADS; t++) cnt_q[t] <= '0;
            err_q        <= '0;
            res_valid_q  <= 1'b0;
            res_thread_q <= '0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
            res_torf_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            res_valid_q  <= res_valid_d;
            res_thread_q <= res_thread_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
            res_torf_q   <= res_torf_d;
        end
    end

    // Stack storage write port; accept already excludes reset cycles.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[op_thread][wr_addr] <= wr_data;
    end

endmodule
